dds_wave_gen: RTL and testbench

Parametrised direct-digital-synthesis waveform source: the next generation of the tick-driven ROM sine generator. It contains an internal sample-tick divider, a phase accumulator with a programmable tuning word, a quarter-wave sine ROM with symmetry folding, four waveform modes and amplitude scaling. It emits one offset-binary sample per tick with a valid strobe, ready to drive spi2dac and pwm directly.

---
 rtl/dds_pkg.sv | 30 +++
 rtl/quarter_sine_rom.sv | 42 ++++
 rtl/dds_wave_gen.sv | 129 ++++++++++++
 tb/tb_dds_wave_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// ----------------------------------------------------------------------------
// dds_pkg: shared mode encodings, midscale helper and parameter legality check.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dds_pkg;

   typedef enum logic [1:0] {
      MODE_SINE = 2'd0,
      MODE_TRI  = 2'd1,
      MODE_SAW  = 2'd2,
      MODE_SQR  = 2'd3
   } mode_e;

   function automatic int unsigned midscale(input int unsigned data_w);
      return 32'd1 << (data_w - 1);
   endfunction

   function automatic bit params_ok(input int tick_div, input int phase_w,
                                    input int fw_w, input int addr_w,
                                    input int data_w, input int amp_w);
      return (tick_div >= 4) && (phase_w >= data_w + 1) && (phase_w >= addr_w) &&
             (fw_w >= 1) && (fw_w <= phase_w) && (addr_w >= 3) &&
             (data_w >= 2) && (amp_w >= 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/quarter_sine_rom.sv
// ----------------------------------------------------------------------------
// quarter_sine_rom: registered quarter-wave sine magnitude table.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module quarter_sine_rom #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 10
) (
   input  logic              clk_i,
   input  logic [ADDR_W-3:0] addr_i,
   output logic [DATA_W-2:0] mag_o
);

   localparam int  c_depth   = 2 ** (ADDR_W - 2);
   localparam int  c_peak    = 2 ** (DATA_W - 1) - 1;
   localparam real c_half_pi = 1.5707963267948966;

   // Half-step sample offset keeps the table monotone with no repeated peak.
   function automatic logic [DATA_W-2:0] mag_at(input int idx);
      real ang;
      ang = c_half_pi * (real'(idx) + 0.5) / real'(c_depth);
      return (DATA_W-1)'($rtoi(real'(c_peak) * $sin(ang) + 0.5));
   endfunction

   logic [DATA_W-2:0] w_table [c_depth];
   logic [DATA_W-2:0] mag_q;

   for (genvar gi = 0; gi < c_depth; gi++) begin : g_rom
      assign w_table[gi] = mag_at(gi);
   end

   always_ff @(posedge clk_i) begin
      mag_q <= w_table[addr_i];
   end

   assign mag_o = mag_q;

endmodule

`default_nettype wire

// File: rtl/dds_wave_gen.sv
// ----------------------------------------------------------------------------
// dds_wave_gen: tick-driven DDS source (sine/triangle/saw/square) with gain.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dds_wave_gen
   import dds_pkg::*;
#(
   parameter int TICK_DIV = 5000,
   parameter int PHASE_W  = 16,
   parameter int FW_W     = 10,
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 10,
   parameter int AMP_W    = 8
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   input  logic              en,
   input  logic              phase_clr,
   input  logic [FW_W-1:0]   freq_word,
   input  logic [1:0]        mode,
   input  logic [AMP_W-1:0]  amp,
   output logic              tick_out,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid
);

   localparam int                  c_div_w    = $clog2(TICK_DIV);
   localparam logic [c_div_w-1:0]  c_div_last = c_div_w'(TICK_DIV - 1);
   localparam logic [DATA_W-1:0]   c_mid      = DATA_W'(midscale(DATA_W));
   localparam int                  c_prod_w   = DATA_W + AMP_W + 2;

   if (!params_ok(TICK_DIV, PHASE_W, FW_W, ADDR_W, DATA_W, AMP_W)) begin : g_bad_params
      $error("dds_wave_gen: illegal parameter combination");
   end

   logic [c_div_w-1:0]  div_q, div_d;
   logic [PHASE_W-1:0]  phase_q, phase_d;
   mode_e               mode_q;
   logic [AMP_W-1:0]    amp_q;
   logic                v1_q, v2_q, valid_q;
   logic [DATA_W:0]     top_q;
   logic [DATA_W-1:0]   data_q, data_d;

   logic                w_tick;
   logic [ADDR_W-3:0]   w_addr;
   logic [ADDR_W-3:0]   w_rom_addr;
   logic [DATA_W-2:0]   w_mag;
   logic [DATA_W-1:0]   w_raw;
   logic signed [DATA_W-1:0]   w_s;
   logic [AMP_W:0]             w_gain;
   logic signed [c_prod_w-1:0] w_prod;
   logic [DATA_W-1:0]          w_scaled;

   always_comb begin
      w_tick = en && (div_q == c_div_last);
      if (!en || w_tick) div_d = '0;
      else               div_d = div_q + c_div_w'(1);

      if (phase_clr)   phase_d = '0;
      else if (w_tick) phase_d = phase_q + PHASE_W'(freq_word);
      else             phase_d = phase_q;
   end

   // Odd quadrants walk the quarter table backwards.
   assign w_addr     = phase_q[PHASE_W-3 -: ADDR_W-2];
   assign w_rom_addr = phase_q[PHASE_W-2] ? ~w_addr : w_addr;

   quarter_sine_rom #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_rom (
      .clk_i  (CLOCK_50),
      .addr_i (w_rom_addr),
      .mag_o  (w_mag)
   );

   always_comb begin
      w_raw = '0;
      case (mode_q)
         MODE_SINE: w_raw = top_q[DATA_W] ? {1'b0, ~w_mag} : {1'b1, w_mag};
         MODE_TRI:  w_raw = top_q[DATA_W] ? ~top_q[DATA_W-1:0] : top_q[DATA_W-1:0];
         MODE_SAW:  w_raw = top_q[DATA_W:1];
         MODE_SQR:  w_raw = top_q[DATA_W] ? '0 : '1;
         default:   w_raw = c_mid;
      endcase
   end

   // Offset-binary <-> two's complement is a flip of the MSB.
   assign w_s      = {~w_raw[DATA_W-1], w_raw[DATA_W-2:0]};
   assign w_gain   = {1'b0, amp_q} + (AMP_W+1)'(1);
   assign w_prod   = c_prod_w'(w_s) * $signed(c_prod_w'({1'b0, w_gain}));
   assign w_scaled = DATA_W'(w_prod >>> AMP_W);
   assign data_d   = {~w_scaled[DATA_W-1], w_scaled[DATA_W-2:0]};

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         div_q   <= '0;
         phase_q <= '0;
         mode_q  <= MODE_SINE;
         amp_q   <= '0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         valid_q <= 1'b0;
         top_q   <= '0;
         data_q  <= c_mid;
      end else begin
         div_q   <= div_d;
         phase_q <= phase_d;
         v1_q    <= w_tick;
         v2_q    <= v1_q;
         valid_q <= v2_q;
         if (w_tick) begin
            mode_q <= mode_e'(mode);
            amp_q  <= amp;
         end
         if (v1_q) top_q  <= phase_q[PHASE_W-1 -: DATA_W+1];
         if (v2_q) data_q <= data_d;
      end
   end

   assign tick_out   = w_tick;
   assign data_out   = data_q;
   assign data_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_dds_wave_gen.sv
// ----------------------------------------------------------------------------
// tb_dds_wave_gen: randomized + directed self-checking bench with a sample model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dds_wave_gen;

   localparam int TD = 4;
   localparam int M  = 512;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        en    = 1'b0;
   logic        clr   = 1'b0;
   logic [15:0] fw    = 16'h0;
   logic [1:0]  mode  = 2'd0;
   logic [7:0]  amp   = 8'hFF;
   logic        tick;
   logic [9:0]  dout;
   logic        dval;

   always #5 clk = ~clk;

   dds_wave_gen #(
      .TICK_DIV (TD),
      .PHASE_W  (16),
      .FW_W     (16),
      .ADDR_W   (10),
      .DATA_W   (10),
      .AMP_W    (8)
   ) dut (
      .CLOCK_50   (clk),
      .RESET_N    (rst_n),
      .en         (en),
      .phase_clr  (clr),
      .freq_word  (fw),
      .mode       (mode),
      .amp        (amp),
      .tick_out   (tick),
      .data_out   (dout),
      .data_valid (dval)
   );

   int tests = 0;
   int fails = 0;

   typedef struct { int due; int val; } pend_t;
   pend_t pend[$];
   int    got[$];
   int    cnt  = 0;
   int    ph   = 0;
   int    cyc  = 0;
   int    held = M;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Output value for a given post-update phase, straight from the waveform rules.
   function automatic int model_sample(input int p, input int md, input int am);
      int q, a, idx, mag, t, r, s;
      case (md)
         0: begin
            q   = p >> 14;
            a   = (p >> 6) & 255;
            idx = (q % 2 == 1) ? 255 - a : a;
            mag = $rtoi(511.0 * $sin(3.14159265358979323846 * (real'(idx) + 0.5) / 512.0) + 0.5);
            r   = (q < 2) ? M + mag : M - 1 - mag;
         end
         1: begin
            t = (p >> 5) & 1023;
            r = (p >= 32768) ? 1023 - t : t;
         end
         2: r = p >> 6;
         default: r = (p >= 32768) ? 0 : 1023;
      endcase
      s = r - M;
      return M + ((s * (am + 1)) >>> 8);
   endfunction

   // Compare process: checks every cycle, then advances the model to the next edge.
   initial begin
      forever begin
         @(negedge clk);
         begin
            bit exp_tick, exp_valid, tk;
            int v;
            if (!rst_n) begin
               cnt = 0; ph = 0; held = M;
               pend.delete();
            end
            exp_tick  = rst_n && en && (cnt == TD - 1);
            exp_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
               exp_valid = 1'b1;
               held = pend[0].val;
               void'(pend.pop_front());
            end
            chk("tick_out", int'(tick), int'(exp_tick));
            chk("data_valid", int'(dval), int'(exp_valid));
            chk("data_out", int'(dout), held);
            if (dval) got.push_back(int'(dout));
            if (rst_n) begin
               tk  = en && (cnt == TD - 1);
               cnt = (en && !tk) ? cnt + 1 : 0;
               if (clr)     ph = 0;
               else if (tk) ph = (ph + int'(fw)) % 65536;
               if (tk) begin
                  v = model_sample(ph, int'(mode), int'(amp));
                  pend.push_back('{due: cyc + 3, val: v});
               end
            end
            cyc++;
         end
      end
   end

   task automatic wait_tick(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (tick) seen = 1'b1;
      end
      if (!seen) chk({name, "_tick_timeout"}, 0, 1);
   endtask

   task automatic run_directed(input string name, input logic [15:0] f, input logic [1:0] md,
                               input logic [7:0] a, input int e0, input int e1, input int e2);
      int n;
      bit seen;
      @(posedge clk); #1;
      rst_n = 1'b0; en = 1'b1; clr = 1'b0; fw = f; mode = md; amp = a;
      got.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_tick(name);
      n = 0; seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         n++;
         if (dval) seen = 1'b1;
      end
      chk({name, "_latency"}, n, 3);
      for (int i = 0; i < 60 && got.size() < 3; i++) @(posedge clk);
      chk({name, "_count"}, (got.size() >= 3) ? 1 : 0, 1);
      chk({name, "_s0"}, (got.size() > 0) ? got[0] : -1, e0);
      chk({name, "_s1"}, (got.size() > 1) ? got[1] : -1, e1);
      chk({name, "_s2"}, (got.size() > 2) ? got[2] : -1, e2);
   endtask

   initial begin
      int n_tick, n_val, first, n;
      bit seen;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1; en = 1'b1; fw = 16'h4000; mode = 2'd0; amp = 8'hFF;
      repeat (10) @(posedge clk);

      // Asynchronous reset mid-run, then tick cadence after release.
      #3 rst_n = 1'b0;
      #1;
      chk("rst_data_out", int'(dout), 512);
      chk("rst_valid", int'(dval), 0);
      chk("rst_tick", int'(tick), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      n_tick = 0; first = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (tick) begin
            n_tick++;
            if (first == 0) first = i;
         end
      end
      chk("first_tick_pos", first, 4);
      chk("ticks_in_12", n_tick, 3);

      run_directed("sine_quad", 16'h4000, 2'd0, 8'hFF, 1023, 509, 0);
      run_directed("square_gain", 16'h8000, 2'd3, 8'd127, 256, 767, 256);
      run_directed("saw_wrap", 16'h8000, 2'd2, 8'hFF, 512, 0, 512);

      // phase_clr coinciding with a tick.
      @(posedge clk); #1;
      rst_n = 1'b0; fw = 16'h1000; mode = 2'd0; amp = 8'hFF;
      @(posedge clk); #1 rst_n = 1'b1;
      wait_tick("clr");
      repeat (4) @(posedge clk);
      #1 clr = 1'b1;
      chk("clr_on_tick", int'(tick), 1);
      got.delete();
      @(posedge clk); #1 clr = 1'b0;
      for (int i = 0; i < 40 && got.size() < 2; i++) @(posedge clk);
      chk("clr_s0", (got.size() > 0) ? got[0] : -1, 514);
      chk("clr_s1", (got.size() > 1) ? got[1] : -1, 709);

      // Enable low: no ticks, no new valids once in-flight samples drain.
      @(posedge clk); #1 en = 1'b0;
      n_tick = 0; n_val = 0;
      for (int i = 1; i <= 3 * TD; i++) begin
         @(negedge clk);
         if (tick) n_tick++;
         if (dval && i > 3) n_val++;
      end
      chk("en0_ticks", n_tick, 0);
      chk("en0_valids", n_val, 0);
      @(posedge clk); #1 en = 1'b1;
      n = 0; seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         n++;
         if (tick) seen = 1'b1;
      end
      chk("reenable_tick_pos", n, TD);

      // Reset one cycle after a tick drops that sample.
      wait_tick("rst_pipe");
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      n_val = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (dval) n_val++;
      end
      chk("rst_pipe_valids", n_val, 0);

      // Randomized run against the model.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         rst_n = ($urandom_range(0, 399) != 0);
         en    = ($urandom_range(0, 9) != 0);
         clr   = ($urandom_range(0, 15) == 0);
         mode  = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       amp = 8'hFF;
            1:       amp = 8'h00;
            default: amp = 8'($urandom);
         endcase
         case ($urandom_range(0, 4))
            0:       fw = 16'h0;
            1:       fw = 16'($urandom_range(0, 64));
            default: fw = 16'($urandom);
         endcase
      end
      @(posedge clk); #1 rst_n = 1'b1; clr = 1'b0;
      repeat (10) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
